io_input_port: RTL and testbench

//  Memory-mapped input peripheral on the CPU read_data bus, beside the RAM tsd drivers.

---
 rtl/io_input_port.sv | 99 +++++++++
 tb/tb_io_input_port.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_port.sv
// Memory-mapped input port: synchronised, debounced switches and keys
// with sticky press events that clear on the first cycle of a read.
module io_input_port #(
    parameter int         DB_CYCLES = 50000,
    parameter logic [8:0] SW_ADDR   = 9'h140,
    parameter logic [8:0] KEY_ADDR  = 9'h141
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  sw_raw,
    input  logic [1:0]  key_raw,
    input  logic [8:0]  mem_addr,
    input  logic [1:0]  mem_cmd,
    output logic [15:0] read_data,
    output logic        read_en
);

    localparam int          CW      = $clog2(DB_CYCLES);
    localparam logic [9:0]  RST_V   = 10'h300;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [9:0]    raw;
    logic [9:0]    s1_q;
    logic [9:0]    s2_q;
    logic [9:0]    stab_q;
    logic [9:0]    stab_d;
    logic [CW-1:0] cnt_q [10];
    logic [CW-1:0] cnt_d [10];
    logic [1:0]    evt_q;
    logic [1:0]    evt_d;
    logic [1:0]    snap_q;
    logic [1:0]    snap_d;
    logic [1:0]    press;
    logic          acc_q;
    logic          rd;
    logic          sw_sel;
    logic          kr;
    logic          first;

    // keys occupy bits 9:8 so one debounce loop serves all inputs
    assign raw = {key_raw, sw_raw};

    always_comb begin
        stab_d = stab_q;
        for (int i = 0; i < 10; i++) begin
            if (s2_q[i] == stab_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stab_d[i] = s2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    assign press  = stab_q[9:8] & ~stab_d[9:8];
    assign rd     = (mem_cmd == 2'b10);
    assign sw_sel = rd && (mem_addr == SW_ADDR);
    assign kr     = rd && (mem_addr == KEY_ADDR);
    assign first  = kr & ~acc_q;

    // a press landing on the clearing edge survives (set wins)
    assign evt_d  = (first ? 2'b00 : evt_q) | press;
    assign snap_d = first ? evt_q : snap_q;

    assign read_en = sw_sel | kr;

    always_comb begin
        read_data = 16'h0000;
        unique case (1'b1)
            sw_sel:  read_data = {8'h00, stab_q[7:0]};
            kr:      read_data = {6'b0, (first ? evt_q : snap_q),
                                  6'b0, ~stab_q[9:8]};
            default: read_data = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= RST_V;
            s2_q   <= RST_V;
            stab_q <= RST_V;
            for (int i = 0; i < 10; i++) cnt_q[i] <= '0;
            evt_q  <= 2'b00;
            snap_q <= 2'b00;
            acc_q  <= 1'b0;
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            stab_q <= stab_d;
            for (int i = 0; i < 10; i++) cnt_q[i] <= cnt_d[i];
            evt_q  <= evt_d;
            snap_q <= snap_d;
            acc_q  <= kr;
        end
    end

endmodule

// File: tb/tb_io_input_port.sv
// Bench for io_input_port: directed scenarios plus random traffic
// checked against a run-length debounce / event model.
module tb_io_input_port;

    localparam int         DB     = 4;
    localparam logic [8:0] A_SW   = 9'h140;
    localparam logic [8:0] A_KEY  = 9'h141;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  sw_raw = 8'h00;
    logic [1:0]  key_raw = 2'b11;
    logic [8:0]  mem_addr = 9'h000;
    logic [1:0]  mem_cmd = 2'b00;
    logic [15:0] read_data;
    logic        read_en;

    io_input_port #(
        .DB_CYCLES(DB),
        .SW_ADDR  (A_SW),
        .KEY_ADDR (A_KEY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .key_raw  (key_raw),
        .mem_addr (mem_addr),
        .mem_cmd  (mem_cmd),
        .read_data(read_data),
        .read_en  (read_en)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        nx_rst  = 1'b1;
    logic [7:0]  nx_sw   = 8'h00;
    logic [1:0]  nx_key  = 2'b11;
    logic [8:0]  nx_addr = 9'h000;
    logic [1:0]  nx_cmd  = 2'b00;

    // model: inputs seen two edges late; level accepted after DB
    // consecutive differing samples
    logic [9:0]  m_d1, m_d2, m_lvl;
    int          m_run [10];
    logic [1:0]  m_evt, m_snap;
    bit          m_acc;
    bit          m_valid = 0;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [1:0] pr;
        bit kr;
        bit fst;
        if (nx_rst) begin
            m_d1 = 10'h300; m_d2 = 10'h300; m_lvl = 10'h300;
            for (int i = 0; i < 10; i++) m_run[i] = 0;
            m_evt = 0; m_snap = 0; m_acc = 0;
            m_valid = 1;
            return;
        end
        pr = 2'b00;
        for (int i = 0; i < 10; i++) begin
            if (m_d2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    if (i >= 8 && m_lvl[i]) pr[i-8] = 1'b1;
                    m_lvl[i] = m_d2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_d2 = m_d1;
        m_d1 = {nx_key, nx_sw};
        kr  = (nx_cmd == 2'b10) && (nx_addr == A_KEY);
        fst = kr && !m_acc;
        if (fst) begin
            m_snap = m_evt;
            m_evt  = 2'b00;
        end
        m_evt = m_evt | pr;
        m_acc = kr;
    endtask

    task automatic step(input string tag = "", input bit has_exp = 0,
                        input logic [15:0] exp = 16'h0000);
        logic        e_en;
        logic [15:0] e_dat;
        @(negedge clk);
        reset    = nx_rst;
        sw_raw   = nx_sw;
        key_raw  = nx_key;
        mem_addr = nx_addr;
        mem_cmd  = nx_cmd;
        #1;
        if (m_valid) begin
            e_en  = (nx_cmd == 2'b10) &&
                    (nx_addr == A_SW || nx_addr == A_KEY);
            e_dat = 16'h0000;
            if (e_en && nx_addr == A_SW)
                e_dat = {8'h00, m_lvl[7:0]};
            else if (e_en)
                e_dat = {6'b0, (m_acc ? m_snap : m_evt), 6'b0, ~m_lvl[9:8]};
            check("model_en", {15'b0, read_en}, {15'b0, e_en});
            check("model_data", read_data, e_dat);
        end
        if (has_exp) check(tag, read_data, exp);
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input int n);
        nx_cmd = 2'b00;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd(input logic [8:0] a, input string tag,
                      input logic [15:0] exp);
        nx_addr = a;
        nx_cmd  = 2'b10;
        step(tag, 1, exp);
    endtask

    initial begin
        nx_rst = 1'b1;
        step();
        step();
        nx_rst = 1'b0;

        // reset state
        rd(A_SW, "t1_sw", 16'h0000);
        check("t1_en", {15'b0, read_en}, 16'h0001);
        nx_cmd = 2'b00; step();
        rd(A_KEY, "t1_key", 16'h0000);
        check("t1_key_en", {15'b0, read_en}, 16'h0001);
        idle(2);

        // debounce latency: change sampled on edge 1, visible after edge 6
        nx_sw = 8'hA5;
        rd(A_SW, "t2_e0", 16'h0000);
        for (int n = 2; n <= 7; n++)
            rd(A_SW, "t2_lat", (n < 7) ? 16'h0000 : 16'h00A5);
        nx_sw = 8'hA4;
        for (int n = 0; n < 3; n++) rd(A_SW, "t2_glitch", 16'h00A5);
        nx_sw = 8'hA5;
        for (int n = 0; n < 8; n++) rd(A_SW, "t2_glitch", 16'h00A5);
        idle(1);

        // key0 press
        nx_key = 2'b10;
        idle(8);
        rd(A_KEY, "t3_first", 16'h0101);
        idle(1);
        rd(A_KEY, "t3_next", 16'h0001);
        nx_key = 2'b11;
        idle(8);
        rd(A_KEY, "t3_rel", 16'h0000);
        idle(1);

        // multi-cycle access holds the snapshot
        nx_key = 2'b01;
        idle(8);
        for (int n = 0; n < 3; n++) rd(A_KEY, "t4_hold", 16'h0202);
        idle(1);
        rd(A_KEY, "t4_new", 16'h0002);
        nx_key = 2'b11;
        idle(8);
        rd(A_KEY, "t4_rel", 16'h0000);
        idle(1);

        // press lands on the clearing edge
        nx_key = 2'b10;
        idle(5);
        rd(A_KEY, "t5_race", 16'h0000);
        idle(1);
        rd(A_KEY, "t5_after", 16'h0101);
        nx_key = 2'b11;
        idle(8);
        nx_key = 2'b10;
        idle(8);

        // reset during debounce and held access
        nx_sw = 8'h3C;
        rd(A_KEY, "t6_a", 16'h0101);
        rd(A_KEY, "t6_b", 16'h0101);
        nx_rst = 1'b1;
        rd(A_KEY, "t6_c", 16'h0101);
        nx_rst = 1'b0;
        rd(A_KEY, "t6_key_rst", 16'h0000);
        nx_cmd = 2'b00; step();
        rd(A_SW, "t6_sw_rst", 16'h0000);
        nx_cmd = 2'b01; nx_addr = A_SW;
        step("t6_wr_sw", 1, 16'h0000);
        check("t6_wr_sw_en", {15'b0, read_en}, 16'h0000);
        nx_addr = A_KEY;
        step("t6_wr_key", 1, 16'h0000);
        check("t6_wr_key_en", {15'b0, read_en}, 16'h0000);
        idle(10);
        rd(A_SW, "t6_sw_after", 16'h003C);
        idle(1);
        rd(A_KEY, "t6_key_after", 16'h0101);
        idle(1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            nx_rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) nx_sw = 8'($urandom);
            if ($urandom_range(0, 5) == 0) nx_key = 2'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 3))
                    0:       nx_addr = A_SW;
                    1, 2:    nx_addr = A_KEY;
                    default: nx_addr = 9'($urandom);
                endcase
                nx_cmd = 2'($urandom);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
